// File: rtl/irq_pending_dispatch_if.sv
// Handshake/bus bundle for irq_pending_dispatch.
// The mask signal exists only when IRQ_DISPATCH_MASK_EN is defined.
interface irq_pending_dispatch_if #(
  parameter int N     = 32,
  parameter int IDX_W = 5
);
  logic [N-1:0]     req;
  logic             clr_all;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_ready;
  logic [N-1:0]     pending;
  logic             overflow;
`ifdef IRQ_DISPATCH_MASK_EN
  logic [N-1:0]     mask;
`endif

  modport master (
`ifdef IRQ_DISPATCH_MASK_EN
    input  mask,
`endif
    input  req, clr_all, out_ready,
    output out_valid, out_idx, pending, overflow
  );

  modport slave (
`ifdef IRQ_DISPATCH_MASK_EN
    output mask,
`endif
    output req, clr_all, out_ready,
    input  out_valid, out_idx, pending, overflow
  );
endinterface

// File: rtl/irq_pending_dispatch.sv
// Pending-request capture and lowest-index-first dispatch over valid/ready.
// Optional selection mask enabled by defining IRQ_DISPATCH_MASK_EN.
module irq_pending_dispatch #(
  parameter int N     = 32,
  parameter int IDX_W = 5,
  parameter bit EDGE  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  irq_pending_dispatch_if.master bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     req_prev_q;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  logic [N-1:0]     new_req_s;
  logic [N-1:0]     retire_s;
  logic [N-1:0]     eligible_s;
  logic [IDX_W-1:0] select_s;
  logic             accept_s;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      r = v[i] ? IDX_W'(i) : r;
    end
    return r;
  endfunction

  // Capture, retire and overflow bookkeeping; a set in the retire cycle keeps the bit pending.
  always_comb begin
    if (EDGE) begin
      new_req_s = bus.req & ~req_prev_q;
    end else begin
      new_req_s = bus.req;
    end
    accept_s   = out_valid_q & bus.out_ready;
    retire_s   = accept_s ? (ONE_HOT0 << out_idx_q) : {N{1'b0}};
    pending_d  = (pending_q & ~retire_s) | new_req_s;
    overflow_d = overflow_q | (|(new_req_s & pending_q & ~retire_s));
`ifdef IRQ_DISPATCH_MASK_EN
    eligible_s = pending_q & ~bus.mask;
`else
    eligible_s = pending_q;
`endif
    select_s   = lowest_idx(eligible_s);
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|eligible_s) state_d = OFFER;
        else             state_d = IDLE;
      end
      OFFER: begin
        if (accept_s) state_d = IDLE;
        else          state_d = OFFER;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: an offer is latched from IDLE and held unchanged until accepted
  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      IDLE: begin
        if (|eligible_s) begin
          out_valid_d = 1'b1;
          out_idx_d   = select_s;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      OFFER: begin
        if (accept_s) out_valid_d = 1'b0;
        else          out_valid_d = 1'b1;
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  // FSM state register; clr_all returns to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              state_q <= IDLE;
    else if (bus.clr_all) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // Data registers; clr_all flushes pending, overflow and the live offer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= {N{1'b0}};
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= {IDX_W{1'b0}};
    end else if (bus.clr_all) begin
      pending_q   <= {N{1'b0}};
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= out_idx_q;
    end else begin
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Previous req sample keeps tracking through clr_all so a held level is not a new edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_prev_q <= {N{1'b0}};
    else     req_prev_q <= bus.req;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_irq_pending_dispatch.sv
// Scoreboard bench: an edge-mode and a level-mode dispatcher share stimulus; a
// transaction-level model predicts pending/overflow/valid per cycle and the offer order.
module tb_irq_pending_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_s = 32'h0;
  logic        clr_s = 1'b0;
  logic        rdy_s = 1'b0;
  logic [31:0] mask_s = 32'h0;

  always #5 clk = ~clk;

  irq_pending_dispatch_if #(.N(32), .IDX_W(5)) bus0 ();
  irq_pending_dispatch_if #(.N(32), .IDX_W(5)) bus1 ();

  assign bus0.req = req_s;  assign bus0.clr_all = clr_s;  assign bus0.out_ready = rdy_s;
  assign bus1.req = req_s;  assign bus1.clr_all = clr_s;  assign bus1.out_ready = rdy_s;
`ifdef IRQ_DISPATCH_MASK_EN
  assign bus0.mask = mask_s;
  assign bus1.mask = mask_s;
`endif

  irq_pending_dispatch #(.N(32), .IDX_W(5), .EDGE(1'b1)) dut_edge (.clk(clk), .rst(rst), .bus(bus0));
  irq_pending_dispatch #(.N(32), .IDX_W(5), .EDGE(1'b0)) dut_lvl  (.clk(clk), .rst(rst), .bus(bus1));

  logic [31:0] o_pend [2];
  logic        o_ovf  [2];
  logic        o_vld  [2];
  logic [4:0]  o_idx  [2];
  assign o_pend[0] = bus0.pending;  assign o_pend[1] = bus1.pending;
  assign o_ovf[0]  = bus0.overflow; assign o_ovf[1]  = bus1.overflow;
  assign o_vld[0]  = bus0.out_valid; assign o_vld[1] = bus1.out_valid;
  assign o_idx[0]  = bus0.out_idx;  assign o_idx[1]  = bus1.out_idx;

  typedef struct {
    logic [31:0] pend;
    logic        ovf;
    logic        vld;
  } st_t;

  st_t q_st  [2][$];
  int  q_off [2][$];

  int checks = 0;
  int errors = 0;

  // Reference model: pending set per dut, index under offer (-1 = none)
  logic [31:0] m_pend [2];
  logic        m_ovf  [2];
  int          m_off  [2];
  logic [31:0] m_prev;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [31:0] r, input logic c, input logic rd, input logic [31:0] m);
    logic [31:0] nr, ret, elig;
    logic        acc, idle;
    int          sel;
    for (int d = 0; d < 2; d++) begin
      if (c) begin
        m_pend[d] = 32'h0;
        m_ovf[d]  = 1'b0;
        m_off[d]  = -1;
      end else begin
        nr   = (d == 0) ? (r & ~m_prev) : r;
        acc  = (m_off[d] >= 0) && rd;
        ret  = acc ? (32'h1 << m_off[d]) : 32'h0;
        idle = (m_off[d] < 0);
        elig = m_pend[d] & ~m;
        if ((nr & m_pend[d] & ~ret) != 32'h0) m_ovf[d] = 1'b1;
        m_pend[d] = (m_pend[d] & ~ret) | nr;
        if (acc) begin
          m_off[d] = -1;
        end else if (idle && elig != 32'h0) begin
          sel = 0;
          for (int i = 31; i >= 0; i--) if (elig[i]) sel = i;
          m_off[d] = sel;
          q_off[d].push_back(sel);
        end
      end
    end
    m_prev = r;
  endtask

  // One clock of stimulus: drive after the edge, log expected state, advance the model
  task automatic step(input logic [31:0] r, input logic c, input logic rd, input logic [31:0] m);
    st_t e;
    @(posedge clk); #1;
    req_s = r; clr_s = c; rdy_s = rd; mask_s = m;
    for (int d = 0; d < 2; d++) begin
      e.pend = m_pend[d];
      e.ovf  = m_ovf[d];
      e.vld  = (m_off[d] >= 0);
      q_st[d].push_back(e);
    end
    model_step(r, c, rd, m);
  endtask

  task automatic idle(input int n, input logic rd, input logic [31:0] m);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, rd, m);
  endtask

  // Monitor: compare DUT state mid-cycle against the oldest expectation
  bit pv  [2] = '{1'b0, 1'b0};
  int cur [2] = '{0, 0};
  always @(negedge clk) begin
    st_t e;
    for (int d = 0; d < 2; d++) begin
      if (q_st[d].size() > 0) begin
        e = q_st[d].pop_front();
        chk("pending", d, o_pend[d], e.pend);
        chk("overflow", d, {31'h0, o_ovf[d]}, {31'h0, e.ovf});
        chk("out_valid", d, {31'h0, o_vld[d]}, {31'h0, e.vld});
        if (e.vld && !pv[d]) begin
          if (q_off[d].size() == 0) begin
            checks++; errors++;
            $display("FAIL offer_queue dut%0d got empty expected an index", d);
          end else begin
            cur[d] = q_off[d].pop_front();
          end
        end
        if (e.vld) chk("out_idx", d, {27'h0, o_idx[d]}, cur[d]);
        pv[d] = e.vld;
      end
    end
  end

  initial begin
    logic [31:0] r, m;
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 32'h0; m_ovf[d] = 1'b0; m_off[d] = -1;
    end
    m_prev = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_pending", d, o_pend[d], 32'h0);
      chk("rst_valid", d, {31'h0, o_vld[d]}, 32'h0);
      chk("rst_idx", d, {27'h0, o_idx[d]}, 32'h0);
      chk("rst_overflow", d, {31'h0, o_ovf[d]}, 32'h0);
    end
    rst = 1'b0;

    // single request, immediate accept
    step(32'h1, 1'b0, 1'b1, 32'h0);
    idle(5, 1'b1, 32'h0);
    // bits 2 and 7 dispatched in order
    step(32'h84, 1'b0, 1'b1, 32'h0);
    idle(8, 1'b1, 32'h0);
    // held offer is not pre-empted by a higher-priority arrival
    step(32'h80, 1'b0, 1'b0, 32'h0);
    idle(3, 1'b0, 32'h0);
    step(32'h2, 1'b0, 1'b0, 32'h0);
    idle(5, 1'b0, 32'h0);
    idle(6, 1'b1, 32'h0);
    // double pulse of a pending bit raises overflow, then flush
    step(32'h20, 1'b0, 1'b0, 32'h0);
    step(32'h0, 1'b0, 1'b0, 32'h0);
    step(32'h20, 1'b0, 1'b0, 32'h0);
    idle(3, 1'b1, 32'h0);
    step(32'h0, 1'b1, 1'b0, 32'h0);
    idle(3, 1'b1, 32'h0);
    // held level on bit 31
    for (int i = 0; i < 12; i++) step(32'h8000_0000, 1'b0, 1'b1, 32'h0);
    idle(4, 1'b1, 32'h0);
    // clr_all while a level is held: no fresh edge afterwards
    for (int i = 0; i < 3; i++) step(32'h0000_0100, 1'b0, 1'b0, 32'h0);
    step(32'h0000_0100, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step(32'h0000_0100, 1'b0, 1'b1, 32'h0);
    idle(4, 1'b1, 32'h0);
    // all bits at once drain in index order
    step(32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
    idle(70, 1'b1, 32'h0);
`ifdef IRQ_DISPATCH_MASK_EN
    step(32'h9, 1'b0, 1'b1, 32'h1);
    idle(6, 1'b1, 32'h1);
    idle(6, 1'b1, 32'h0);
`endif
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom() & $urandom() & $urandom();
      if ($urandom_range(0, 3) == 0) r = 32'h0;
      m = 32'h0;
`ifdef IRQ_DISPATCH_MASK_EN
      m = $urandom() & $urandom();
`endif
      step(r, ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), m);
    end
    step(32'h0, 1'b1, 1'b0, 32'h0);
    step(32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
    idle(75, 1'b1, 32'h0);
    step(32'h0, 1'b1, 1'b0, 32'h0);
    idle(3, 1'b1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("offers_left", d, q_off[d].size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
